// File: rtl/cpu_seq_pkg.sv
// Shared types for the instruction sequencer: FSM state encoding and the
// per-instruction control flags captured during DECODE.
package cpu_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic wmem;
    logic rmem;
    logic wreg;
    logic wpc;
    logic cond_en;
  } dec_flags_t;

  // States that wait on a memory handshake and are therefore watched by the timer.
  function automatic logic is_wait_state(input seq_state_e st);
    return (st == ST_FETCH) || (st == ST_MEM);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Handshake timeout counter shared by FETCH and MEM. 'expired' flags the
// ack-less cycle that would bring the count up to WAIT_MAX.
module wait_timer #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] count_r;

  assign expired = tick && (count_r == LAST);

  // Count consecutive ack-less cycles; any state change restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (tick && !expired) begin
      count_r <= count_r + 1'b1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional data
// memory access and register write-back, with handshake timeout and sticky fault.
module instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dec_wmem,
  input  logic             dec_rmem,
  input  logic             dec_wreg,
  input  logic             dec_wpc,
  input  logic             dec_cond_en,
  input  logic             branch_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic             flag_we,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  seq_state_e       state_r;
  seq_state_e       state_s;
  seq_state_e       after_retire_s;
  dec_flags_t       flags_r;
  logic [CNT_W-1:0] cnt_r;

  logic timer_clear_s;
  logic timer_tick_s;
  logic timer_expired_s;
  logic mem_conflict_s;

  logic imem_req_s, dmem_req_s, dmem_we_s, ir_we_s, pc_we_s, pc_sel_s;
  logic reg_we_s, flag_we_s, busy_s, fault_s;

  assign mem_conflict_s = flags_r.wmem & flags_r.rmem;
  assign after_retire_s = run ? ST_FETCH : ST_IDLE;

  assign timer_clear_s = (state_s != state_r);
  assign timer_tick_s  = is_wait_state(state_r) &&
                         !((state_r == ST_FETCH) ? imem_ack : dmem_ack);

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_s),
    .tick    (timer_tick_s),
    .expired (timer_expired_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Decoded flags are captured once per instruction and govern it to retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= '{wmem: 1'b0, rmem: 1'b0, wreg: 1'b0, wpc: 1'b0, cond_en: 1'b0};
    end else if (state_r == ST_DECODE) begin
      flags_r <= '{wmem: dec_wmem, rmem: dec_rmem, wreg: dec_wreg,
                   wpc: dec_wpc, cond_en: dec_cond_en};
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (pc_we_s) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Next-state logic; run only matters in IDLE and at retire.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) state_s = ST_FETCH;
        else     state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (imem_ack)             state_s = ST_DECODE;
        else if (timer_expired_s) state_s = ST_FAULT;
        else                      state_s = ST_FETCH;
      end
      ST_DECODE: state_s = ST_EXEC;
      ST_EXEC: begin
        if (mem_conflict_s)                    state_s = ST_FAULT;
        else if (flags_r.wmem || flags_r.rmem) state_s = ST_MEM;
        else if (flags_r.wreg)                 state_s = ST_WB;
        else                                   state_s = after_retire_s;
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (flags_r.rmem) state_s = ST_WB;
          else              state_s = after_retire_s;
        end else if (timer_expired_s) begin
          state_s = ST_FAULT;
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_WB:    state_s = after_retire_s;
      ST_FAULT: state_s = ST_FAULT;
      default:  state_s = ST_FAULT;
    endcase
  end

  // Strobe decode from state and latched flags; everything is forced low under reset.
  always_comb begin
    imem_req_s = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    ir_we_s    = 1'b0;
    pc_we_s    = 1'b0;
    pc_sel_s   = 1'b0;
    reg_we_s   = 1'b0;
    flag_we_s  = 1'b0;
    busy_s     = 1'b0;
    fault_s    = 1'b0;
    if (rst) begin
      busy_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: busy_s = 1'b0;
        ST_FETCH: begin
          busy_s     = 1'b1;
          imem_req_s = 1'b1;
          ir_we_s    = imem_ack;
        end
        ST_DECODE: busy_s = 1'b1;
        ST_EXEC: begin
          busy_s = 1'b1;
          if (mem_conflict_s) begin
            flag_we_s = 1'b0;
          end else begin
            flag_we_s = flags_r.cond_en;
            pc_we_s   = !(flags_r.wmem || flags_r.rmem || flags_r.wreg);
          end
        end
        ST_MEM: begin
          busy_s     = 1'b1;
          dmem_req_s = 1'b1;
          dmem_we_s  = flags_r.wmem;
          pc_we_s    = dmem_ack && flags_r.wmem;
        end
        ST_WB: begin
          busy_s   = 1'b1;
          reg_we_s = 1'b1;
          pc_we_s  = 1'b1;
        end
        ST_FAULT: fault_s = 1'b1;
        default:  fault_s = 1'b1;
      endcase
      pc_sel_s = pc_we_s && flags_r.wpc && branch_taken;
    end
  end

  assign imem_req  = imem_req_s;
  assign dmem_req  = dmem_req_s;
  assign dmem_we   = dmem_we_s;
  assign ir_we     = ir_we_s;
  assign pc_we     = pc_we_s;
  assign pc_sel    = pc_sel_s;
  assign reg_we    = reg_we_s;
  assign flag_we   = flag_we_s;
  assign busy      = busy_s;
  assign fault     = fault_s;
  assign state     = rst ? ST_IDLE : state_r;
  assign instr_cnt = rst ? {CNT_W{1'b0}} : cnt_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle comparison of counter, state
// and every strobe against hand-computed vectors.
module tb_instr_sequencer;
  import cpu_seq_pkg::*;

  localparam int unsigned WAIT_MAX = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned OW       = CNT_W + 13;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  // strobe order: imem_req dmem_req dmem_we ir_we pc_we pc_sel reg_we flag_we busy fault
  localparam logic [9:0] F_IDLE      = 10'b0000000000;
  localparam logic [9:0] F_FETCH     = 10'b1000000010;
  localparam logic [9:0] F_FETCH_ACK = 10'b1001000010;
  localparam logic [9:0] F_BUSY      = 10'b0000000010;
  localparam logic [9:0] F_WB        = 10'b0000101010;
  localparam logic [9:0] F_JUMP      = 10'b0000110110;
  localparam logic [9:0] F_LOAD      = 10'b0100000010;
  localparam logic [9:0] F_STORE     = 10'b0110100010;
  localparam logic [9:0] F_RETIRE    = 10'b0000100010;
  localparam logic [9:0] F_FAULT     = 10'b0000000001;

  logic clk = 1'b0;
  logic rst, run, dec_wmem, dec_rmem, dec_wreg, dec_wpc, dec_cond_en;
  logic branch_taken, imem_ack, dmem_ack;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, flag_we, busy, fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .dec_wmem(dec_wmem), .dec_rmem(dec_rmem), .dec_wreg(dec_wreg),
    .dec_wpc(dec_wpc), .dec_cond_en(dec_cond_en), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .flag_we(flag_we), .busy(busy), .fault(fault),
    .state(state), .instr_cnt(instr_cnt)
  );

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got cnt=%h st=%0d strb=%b, want cnt=%h st=%0d strb=%b",
               tag, got[OW-1:13], got[12:10], got[9:0], exp[OW-1:13], exp[12:10], exp[9:0]);
    end
  endtask

  function automatic logic [OW-1:0] e(input logic [CNT_W-1:0] c, input seq_state_e s,
                                      input logic [9:0] f);
    return {c, s, f};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {instr_cnt, state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
            reg_we, flag_we, busy, fault};
  endfunction

  // Check the current cycle at the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [OW-1:0] exp);
    @(negedge clk);
    chk(tag, obs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic wm, input logic rm, input logic wr,
                         input logic wp, input logic ce);
    dec_wmem = wm; dec_rmem = rm; dec_wreg = wr; dec_wpc = wp; dec_cond_en = ce;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    step("in_reset", e(8'h00, ST_IDLE, F_IDLE));
    rst = 1'b0; run = 1'b1; imem_ack = 1'b1;
    set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("post_reset", e(8'h00, ST_IDLE, F_IDLE));

    // ALU op; flags changed after DECODE and run dropped mid-instruction
    step("alu_fetch", e(8'h00, ST_FETCH, F_FETCH_ACK));
    step("alu_decode", e(8'h00, ST_DECODE, F_BUSY));
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); run = 1'b0;
    step("alu_exec", e(8'h00, ST_EXEC, F_BUSY));
    step("alu_wb", e(8'h00, ST_WB, F_WB));

    // taken jump with compare; stray dmem_ack must be ignored
    set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1); run = 1'b1; dmem_ack = 1'b1;
    step("jmp_idle", e(8'h01, ST_IDLE, F_IDLE));
    step("jmp_fetch", e(8'h01, ST_FETCH, F_FETCH_ACK));
    step("jmp_decode", e(8'h01, ST_DECODE, F_BUSY));
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); branch_taken = 1'b1; run = 1'b0;
    step("jmp_exec", e(8'h01, ST_EXEC, F_JUMP));

    // load with dmem_ack delayed 3 cycles; branch_taken high but wpc clear
    set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); run = 1'b1; dmem_ack = 1'b0;
    step("ld_idle", e(8'h02, ST_IDLE, F_IDLE));
    step("ld_fetch", e(8'h02, ST_FETCH, F_FETCH_ACK));
    step("ld_decode", e(8'h02, ST_DECODE, F_BUSY));
    run = 1'b0;
    step("ld_exec", e(8'h02, ST_EXEC, F_BUSY));
    for (int i = 0; i < 3; i++) step("ld_mem_wait", e(8'h02, ST_MEM, F_LOAD));
    dmem_ack = 1'b1;
    step("ld_mem_ack", e(8'h02, ST_MEM, F_LOAD));
    dmem_ack = 1'b0;
    step("ld_wb", e(8'h02, ST_WB, F_WB));

    // zero-wait store, run kept high so the next fetch follows directly
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); run = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b0;
    step("st_idle", e(8'h03, ST_IDLE, F_IDLE));
    step("st_fetch", e(8'h03, ST_FETCH, F_FETCH_ACK));
    step("st_decode", e(8'h03, ST_DECODE, F_BUSY));
    step("st_exec", e(8'h03, ST_EXEC, F_BUSY));
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); imem_ack = 1'b0;
    step("st_mem", e(8'h03, ST_MEM, F_STORE));

    // ack in the last allowed cycle is accepted
    for (int i = 1; i < WAIT_MAX; i++) step("to_wait", e(8'h04, ST_FETCH, F_FETCH));
    imem_ack = 1'b1;
    step("to_ack_last", e(8'h04, ST_FETCH, F_FETCH_ACK));
    imem_ack = 1'b0;
    step("to_decode", e(8'h04, ST_DECODE, F_BUSY));
    step("to_exec", e(8'h04, ST_EXEC, F_RETIRE));

    // no ack for WAIT_MAX cycles -> sticky fault
    for (int i = 0; i < WAIT_MAX; i++) step("to_hang", e(8'h05, ST_FETCH, F_FETCH));
    imem_ack = 1'b1; dmem_ack = 1'b1;
    step("to_fault", e(8'h05, ST_FAULT, F_FAULT));
    step("fault_sticky", e(8'h05, ST_FAULT, F_FAULT));

    // wmem and rmem together -> fault after DECODE, no strobes
    rst = 1'b1;
    step("rst_from_fault", e(8'h00, ST_IDLE, F_IDLE));
    rst = 1'b0; run = 1'b1; branch_taken = 1'b1;
    set_dec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("cf_idle", e(8'h00, ST_IDLE, F_IDLE));
    step("cf_fetch", e(8'h00, ST_FETCH, F_FETCH_ACK));
    step("cf_decode", e(8'h00, ST_DECODE, F_BUSY));
    step("cf_exec", e(8'h00, ST_EXEC, F_BUSY));
    step("cf_fault", e(8'h00, ST_FAULT, F_FAULT));

    // counter rollover with back-to-back 3-cycle instructions
    rst = 1'b1;
    step("rst_again", e(8'h00, ST_IDLE, F_IDLE));
    rst = 1'b0; branch_taken = 1'b0; dmem_ack = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ro_idle", e(8'h00, ST_IDLE, F_IDLE));
    repeat (3 * ((1 << CNT_W) - 1)) begin
      @(posedge clk); #1;
    end
    step("ro_fetch", e(CMAX, ST_FETCH, F_FETCH_ACK));
    step("ro_decode", e(CMAX, ST_DECODE, F_BUSY));
    step("ro_exec", e(CMAX, ST_EXEC, F_RETIRE));
    step("ro_wrap", e(8'h00, ST_FETCH, F_FETCH_ACK));
    step("ro_decode2", e(8'h00, ST_DECODE, F_BUSY));
    step("ro_exec2", e(8'h00, ST_EXEC, F_RETIRE));

    // reset mid-MEM with an ack in the same cycle
    set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rm_fetch", e(8'h01, ST_FETCH, F_FETCH_ACK));
    step("rm_decode", e(8'h01, ST_DECODE, F_BUSY));
    step("rm_exec", e(8'h01, ST_EXEC, F_BUSY));
    step("rm_mem", e(8'h01, ST_MEM, F_LOAD));
    rst = 1'b1; dmem_ack = 1'b1;
    step("rm_rst", e(8'h00, ST_IDLE, F_IDLE));
    rst = 1'b0; dmem_ack = 1'b0; run = 1'b0;
    step("rm_after", e(8'h00, ST_IDLE, F_IDLE));
    step("rm_idle_hold", e(8'h00, ST_IDLE, F_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter WAIT_MAX, default 16: maximum consecutive cycles without ack in FETCH or MEM before fault.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 run  in  1  1 = execute continuously; 0 = finish the current instruction, then idle.
REQ-006 dec_wmem, dec_rmem, dec_wreg, dec_wpc, dec_cond_en  in  1 each  decoded control flags from the control unit.
REQ-007 branch_taken  in  1  condition-flag evaluation for the current jump.
REQ-008 imem_ack, dmem_ack  in  1 each  memory completion strobes.
REQ-009 imem_req, dmem_req, dmem_we  out  1 each  memory requests; dmem_we qualifies dmem_req.
REQ-010 ir_we, pc_we, pc_sel, reg_we, flag_we  out  1 each  datapath strobes; pc_sel 1 = branch target, 0 = PC+1.
REQ-011 busy  out  1  high in any state other than IDLE or FAULT.
REQ-012 fault  out  1  sticky error flag.
REQ-013 state  out  3  current FSM state encoding.
REQ-014 instr_cnt  out  CNT_W  retired-instruction count.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
REQ-016 IDLE: run=1 -> FETCH; otherwise stay.
REQ-017 FETCH: hold imem_req=1; imem_ack=1 -> pulse ir_we in the same cycle and go to DECODE.
REQ-018 DECODE: one cycle; latch all dec_* flags into internal registers; the latched values govern the rest of the instruction.
REQ-019 Latched dec_wmem=1 and dec_rmem=1 together -> FAULT on the next edge; no strobes issue.
REQ-020 EXEC: pulse flag_we if cond_en; then wmem|rmem -> MEM, else wreg -> WB, else retire.
REQ-021 MEM: hold dmem_req=1 with dmem_we=wmem; on dmem_ack, rmem -> WB, wmem -> retire.
REQ-022 WB: pulse reg_we for one cycle, then retire.
REQ-023 Retire: pc_we=1 in exactly one cycle per instruction, the last one; pc_sel=wpc & branch_taken, with branch_taken sampled in that same cycle.
REQ-024 After retire, next state is FETCH if run=1 and IDLE if run=0; run is ignored mid-instruction.
REQ-025 instr_cnt increments on every pc_we and wraps from all-ones to 0.
REQ-026 Zero-wait latency: jump/compare-only 3 cycles, ALU 4, store 4, load 5.
REQ-027 Wait counter clears on entry to FETCH and MEM and increments each cycle ack=0; reaching WAIT_MAX -> FAULT on the next edge.
REQ-028 An ack arriving in the same cycle the counter reaches WAIT_MAX is accepted; no fault.
REQ-029 Ack seen outside its requesting state is ignored.
REQ-030 FAULT: all strobes and requests 0, fault=1; exit only by rst.
REQ-031 ir_we, reg_we, flag_we and pc_we are never high for more than one consecutive cycle.

Reset
REQ-032 rst=1 at an edge forces IDLE, instr_cnt=0, fault=0, wait counter=0 and latched flags=0, overriding any transition, including mid-handshake.
REQ-033 All outputs are 0 while in reset and in the first cycle after it.

Structure
REQ-034 State enum type and 3-bit encoding live in shared package cpu_seq_pkg, for use by testbench and debug.
REQ-035 Timeout counter is a sub-module, wait_timer (clear, tick, expired), instantiated once and shared by FETCH and MEM.
REQ-036 Output strobes are decoded combinationally from state and latched flags; no extra output registers.

Verification
REQ-037 ALU op (wreg=1), zero-wait acks, run=1 -> ir_we@c1, reg_we@c4, pc_we@c4, pc_sel=0, instr_cnt 0->1.
REQ-038 Load with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then reg_we and pc_we in the WB cycle; 8 cycles total.
REQ-039 Jump (wpc=1, branch_taken=1) -> pc_we and pc_sel=1 at cycle 3, no reg_we, no dmem_req.
REQ-040 imem_ack held 0 for WAIT_MAX=16 cycles -> fault=1, state=FAULT, outputs 0 until rst; ack on cycle 16 -> DECODE, no fault.
REQ-041 wmem=rmem=1 -> FAULT after DECODE, pc_we never asserted.
REQ-042 rst asserted during MEM, and instr_cnt=0xFFFF rolling over on retire -> IDLE with cnt=0 next cycle; rollover yields 0x0000.
